// File: rtl/la_trigger_sequencer_if.sv
// ---------------------------------------------------------------------------
// la_trigger_sequencer_if
// Bundles the host configuration/control signals and the sample-buffer side
// outputs of the trigger sequencer.
//   master : host register block / sample memory view (drives control+config)
//   slave  : the sequencer itself
// Signals:
//   start, abort, sample_en, trig_vec          control and sample stream
//   stage_mask, stage_or, stage_cnt, stage_last per-stage trigger program
//   pre_depth, post_depth                      capture window
//   busy, triggered, done, cur_stage           status
//   buf_we, buf_addr, trig_addr                sample buffer write port
// Optional (TRIG_TIMEOUT_EN): timeout in, timed_out out.
// ---------------------------------------------------------------------------
interface la_trigger_sequencer_if #(
  parameter int CH_NUM = 8,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 12
);
  logic                      start;
  logic                      abort;
  logic                      sample_en;
  logic [CH_NUM-1:0]         trig_vec;
  logic [STAGES*CH_NUM-1:0]  stage_mask;
  logic [STAGES-1:0]         stage_or;
  logic [STAGES*CNT_W-1:0]   stage_cnt;
  logic [2:0]                stage_last;
  logic [ADDR_W-1:0]         pre_depth;
  logic [ADDR_W-1:0]         post_depth;
  logic                      busy;
  logic                      triggered;
  logic                      done;
  logic [2:0]                cur_stage;
  logic                      buf_we;
  logic [ADDR_W-1:0]         buf_addr;
  logic [ADDR_W-1:0]         trig_addr;
`ifdef TRIG_TIMEOUT_EN
  logic [31:0]               timeout;
  logic                      timed_out;
`endif

  modport master (
`ifdef TRIG_TIMEOUT_EN
    output timeout,
    input  timed_out,
`endif
    output start, abort, sample_en, trig_vec,
    output stage_mask, stage_or, stage_cnt, stage_last,
    output pre_depth, post_depth,
    input  busy, triggered, done, cur_stage,
    input  buf_we, buf_addr, trig_addr
  );

  modport slave (
`ifdef TRIG_TIMEOUT_EN
    input  timeout,
    output timed_out,
`endif
    input  start, abort, sample_en, trig_vec,
    input  stage_mask, stage_or, stage_cnt, stage_last,
    input  pre_depth, post_depth,
    output busy, triggered, done, cur_stage,
    output buf_we, buf_addr, trig_addr
  );
endinterface

// File: rtl/la_trigger_sequencer.sv
// ---------------------------------------------------------------------------
// la_trigger_sequencer
// Multi-stage trigger sequencer and capture-window controller for the logic
// analyzer. Walks up to STAGES programmable trigger stages over the comparator
// match vector and drives the sample buffer write enable/address through the
// pre-trigger fill, trigger wait and post-trigger fill phases.
// Ports:
//   clk   sample-domain clock
//   rstn  asynchronous active-low reset
//   bus   la_trigger_sequencer_if.slave (control, stage program, status,
//         sample buffer write port)
// Optional feature macro: TRIG_TIMEOUT_EN adds a WAIT-phase sample timeout
// (bus.timeout / bus.timed_out) that forces the trigger.
// ---------------------------------------------------------------------------
module la_trigger_sequencer #(
  parameter int CH_NUM = 8,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 rstn,
  la_trigger_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d;
  logic [CNT_W-1:0]    match_cnt_q, match_cnt_d;
  logic [2:0]          stage_q, stage_d;
  logic                triggered_q, triggered_d;
`ifdef TRIG_TIMEOUT_EN
  logic [31:0]         to_cnt_q, to_cnt_d;
  logic                timed_out_q, timed_out_d;
  logic [31:0]         to_nxt;
`endif

  // Stage evaluation: an empty mask is a "don't care" stage in both modes.
  function automatic logic stage_match(input logic [CH_NUM-1:0] tv,
                                       input logic [CH_NUM-1:0] mask,
                                       input logic              use_or);
    if (mask == '0)
      return 1'b1;
    if (use_or)
      return |(tv & mask);
    return &(tv | ~mask);
  endfunction

  // Program of the stage currently being evaluated.
  logic [CH_NUM-1:0] cur_mask;
  logic              cur_or;
  logic [CNT_W-1:0]  cur_cnt;
  logic [2:0]        last_stage;

  always_comb begin
    cur_mask = '0;
    cur_or   = 1'b0;
    cur_cnt  = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (stage_q == 3'(k)) begin
        cur_mask = bus.stage_mask[k*CH_NUM +: CH_NUM];
        cur_or   = bus.stage_or[k];
        cur_cnt  = bus.stage_cnt[k*CNT_W +: CNT_W];
      end
    end
  end

  assign last_stage = (bus.stage_last > 3'(STAGES-1)) ? 3'(STAGES-1) : bus.stage_last;

  logic              hit, stage_done, fire;
  logic [ADDR_W-1:0] post_eff;
  logic [ADDR_W-1:0] addr_nxt, pre_nxt, post_nxt;
  logic              busy_state;

  assign hit        = stage_match(bus.trig_vec, cur_mask, cur_or);
  // Count is "matches minus one", so the final match is seen while the
  // counter still holds stage_cnt.
  assign stage_done = hit && (match_cnt_q == cur_cnt);
  assign post_eff   = (bus.post_depth == '0) ? ADDR_W'(1) : bus.post_depth;
  assign addr_nxt   = addr_q + 1'b1;
  assign pre_nxt    = pre_cnt_q + 1'b1;
  assign post_nxt   = post_cnt_q + 1'b1;
  assign busy_state = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);

`ifdef TRIG_TIMEOUT_EN
  logic to_hit;
  assign to_nxt = to_cnt_q + 32'd1;
  assign to_hit = (bus.timeout != 32'd0) && (to_nxt == bus.timeout);
  assign fire   = (stage_done && (stage_q == last_stage)) || to_hit;
`else
  assign fire   = stage_done && (stage_q == last_stage);
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    trig_addr_d = trig_addr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    match_cnt_d = match_cnt_q;
    stage_d     = stage_q;
    triggered_d = triggered_q;
`ifdef TRIG_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    timed_out_d = timed_out_q;
`endif

    if (bus.abort) begin
      // trig_addr survives an abort so the host can still read it back.
      state_d     = S_IDLE;
      addr_d      = '0;
      pre_cnt_d   = '0;
      post_cnt_d  = '0;
      match_cnt_d = '0;
      stage_d     = '0;
      triggered_d = 1'b0;
`ifdef TRIG_TIMEOUT_EN
      to_cnt_d    = '0;
      timed_out_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_d     = S_PRE;
            addr_d      = '0;
            pre_cnt_d   = '0;
            post_cnt_d  = '0;
            match_cnt_d = '0;
            stage_d     = '0;
            triggered_d = 1'b0;
`ifdef TRIG_TIMEOUT_EN
            to_cnt_d    = '0;
            timed_out_d = 1'b0;
`endif
          end
        end

        S_PRE: begin
          if (bus.sample_en) begin
            addr_d    = addr_nxt;
            pre_cnt_d = pre_nxt;
            if (pre_nxt >= bus.pre_depth)
              state_d = S_WAIT;
          end else if (bus.pre_depth == '0) begin
            state_d = S_WAIT;
          end
        end

        S_WAIT: begin
          if (bus.sample_en) begin
            // Address wraps naturally: circular pre-trigger history.
            addr_d = addr_nxt;
`ifdef TRIG_TIMEOUT_EN
            to_cnt_d = to_nxt;
`endif
            if (fire) begin
              triggered_d = 1'b1;
              trig_addr_d = addr_q;
              match_cnt_d = '0;
`ifdef TRIG_TIMEOUT_EN
              timed_out_d = to_hit;
`endif
              // The trigger sample is the first post sample.
              if (post_eff == ADDR_W'(1)) begin
                state_d = S_DONE;
              end else begin
                state_d    = S_POST;
                post_cnt_d = ADDR_W'(1);
              end
            end else if (stage_done) begin
              match_cnt_d = '0;
              stage_d     = stage_q + 3'd1;
            end else if (hit) begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
          end
        end

        S_POST: begin
          if (bus.sample_en) begin
            addr_d     = addr_nxt;
            post_cnt_d = post_nxt;
            if (post_nxt >= post_eff)
              state_d = S_DONE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      trig_addr_q <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      match_cnt_q <= '0;
      stage_q     <= '0;
      triggered_q <= 1'b0;
`ifdef TRIG_TIMEOUT_EN
      to_cnt_q    <= '0;
      timed_out_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      trig_addr_q <= trig_addr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      match_cnt_q <= match_cnt_d;
      stage_q     <= stage_d;
      triggered_q <= triggered_d;
`ifdef TRIG_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      timed_out_q <= timed_out_d;
`endif
    end
  end

  // Write enable is combinational so the write lands on the current sample.
  assign bus.buf_we    = bus.sample_en & busy_state;
  assign bus.buf_addr  = addr_q;
  assign bus.trig_addr = trig_addr_q;
  assign bus.busy      = busy_state;
  assign bus.done      = (state_q == S_DONE);
  assign bus.triggered = triggered_q;
  assign bus.cur_stage = stage_q;
`ifdef TRIG_TIMEOUT_EN
  assign bus.timed_out = timed_out_q;
`endif

endmodule

// File: tb/tb_la_trigger_sequencer.sv
`timescale 1ns/1ps
module tb_la_trigger_sequencer;
  localparam int CH_NUM = 8;
  localparam int STAGES = 4;
  localparam int CNT_W  = 16;
  localparam int ADDR_W = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  la_trigger_sequencer_if #(.CH_NUM(CH_NUM), .STAGES(STAGES), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus ();

  la_trigger_sequencer #(.CH_NUM(CH_NUM), .STAGES(STAGES), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        stg;
    logic              trg;
  } wr_t;

  typedef struct packed {
    logic              busy;
    logic              trg;
    logic              done;
    logic [2:0]        stg;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] taddr;
    logic              tout;
  } st_t;

  wr_t  wq[$];
  st_t  sq[$];
  int   tests = 0;
  int   fails = 0;
  logic chk_req = 1'b0;
  logic fin_req = 1'b0;

  // Monitor / scoreboard: every buffer write and every requested status
  // snapshot is compared against the next queued expectation.
  initial begin
    wr_t  we, wa;
    st_t  se, sa;
    logic act_to;
    forever begin
      @(negedge clk);
`ifdef TRIG_TIMEOUT_EN
      act_to = bus.timed_out;
`else
      act_to = 1'b0;
`endif
      if (bus.buf_we) begin
        tests++;
        wa = '{addr: bus.buf_addr, stg: bus.cur_stage, trg: bus.triggered};
        if (wq.size() == 0) begin
          fails++;
          $display("FAIL write_unexpected: got write addr=%0d stage=%0d trig=%0b, required no write",
                   wa.addr, wa.stg, wa.trg);
        end else begin
          we = wq.pop_front();
          if (wa !== we) begin
            fails++;
            $display("FAIL write: got addr=%0d stage=%0d trig=%0b, required addr=%0d stage=%0d trig=%0b",
                     wa.addr, wa.stg, wa.trg, we.addr, we.stg, we.trg);
          end
        end
      end
      if (chk_req) begin
        tests++;
        sa = '{busy: bus.busy, trg: bus.triggered, done: bus.done, stg: bus.cur_stage,
               addr: bus.buf_addr, taddr: bus.trig_addr, tout: act_to};
        if (sq.size() == 0) begin
          fails++;
          $display("FAIL status_queue: no expectation queued");
        end else begin
          se = sq.pop_front();
          if (sa !== se) begin
            fails++;
            $display("FAIL status: got busy=%0b trig=%0b done=%0b stage=%0d addr=%0d taddr=%0d tout=%0b, required busy=%0b trig=%0b done=%0b stage=%0d addr=%0d taddr=%0d tout=%0b",
                     sa.busy, sa.trg, sa.done, sa.stg, sa.addr, sa.taddr, sa.tout,
                     se.busy, se.trg, se.done, se.stg, se.addr, se.taddr, se.tout);
          end
        end
      end
      if (fin_req) begin
        tests++;
        if (wq.size() != 0 || sq.size() != 0) begin
          fails++;
          $display("FAIL drain: got %0d writes and %0d status checks outstanding, required 0 and 0",
                   wq.size(), sq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic sample(input logic [7:0] tv, input logic [ADDR_W-1:0] a,
                        input logic [2:0] s, input logic t);
    wr_t e;
    e.addr = a; e.stg = s; e.trg = t;
    wq.push_back(e);
    bus.trig_vec  = tv;
    bus.sample_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic en);
    bus.sample_en = en;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse(input logic st, input logic ab);
    bus.sample_en = 1'b0;
    bus.start     = st;
    bus.abort     = ab;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
  endtask

  task automatic status(input logic b, input logic t, input logic d, input logic [2:0] s,
                        input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] ta, input logic to);
    st_t e;
    e.busy = b; e.trg = t; e.done = d; e.stg = s; e.addr = a; e.taddr = ta; e.tout = to;
    sq.push_back(e);
    bus.sample_en = 1'b0;
    chk_req = 1'b1;
    @(posedge clk); #1;
    chk_req = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] m0, input logic o0, input logic [15:0] c0,
                     input logic [7:0] m1, input logic o1, input logic [15:0] c1,
                     input logic [2:0] last, input logic [ADDR_W-1:0] pre,
                     input logic [ADDR_W-1:0] post);
    bus.stage_mask = {16'h0000, m1, m0};
    bus.stage_or   = {2'b00, o1, o0};
    bus.stage_cnt  = {32'h0, c1, c0};
    bus.stage_last = last;
    bus.pre_depth  = pre;
    bus.post_depth = post;
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    bus.start = 1'b0; bus.abort = 1'b0; bus.sample_en = 1'b0; bus.trig_vec = '0;
    bus.stage_mask = '0; bus.stage_or = '0; bus.stage_cnt = '0; bus.stage_last = '0;
    bus.pre_depth = '0; bus.post_depth = '0;
`ifdef TRIG_TIMEOUT_EN
    bus.timeout = 32'd0;
`endif
    @(posedge clk); #1;
    status(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0);   // in reset
    rstn = 1'b1;
    idle(2, 1'b0);

    // Single AND stage, trigger on 7th sample, 3 post samples
    cfg(8'h01, 1'b0, 16'd0, 8'h00, 1'b0, 16'd0, 3'd0, 4'd4, 4'd3);
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      a = 4'(i);
      sample(8'h00, a, 3'd0, 1'b0);
    end
    sample(8'h00, 4'd4, 3'd0, 1'b0);
    sample(8'h00, 4'd5, 3'd0, 1'b0);
    sample(8'h01, 4'd6, 3'd0, 1'b0);
    sample(8'h00, 4'd7, 3'd0, 1'b1);
    sample(8'h00, 4'd8, 3'd0, 1'b1);
    status(1'b0, 1'b1, 1'b1, 3'd0, 4'd9, 4'd6, 1'b0);
    idle(2, 1'b1);                                        // no writes in DONE
    status(1'b0, 1'b1, 1'b1, 3'd0, 4'd9, 4'd6, 1'b0);

    // Two stages: OR 0x06 x3 (non-consecutive), then AND 0x81
    cfg(8'h06, 1'b1, 16'd2, 8'h81, 1'b0, 16'd0, 3'd1, 4'd1, 4'd1);
    pulse(1'b1, 1'b0);
    sample(8'h00, 4'd0, 3'd0, 1'b0);
    sample(8'h02, 4'd1, 3'd0, 1'b0);
    sample(8'h00, 4'd2, 3'd0, 1'b0);
    sample(8'h04, 4'd3, 3'd0, 1'b0);
    bus.trig_vec = 8'h06;
    idle(10, 1'b0);                                       // frozen with matching input
    status(1'b1, 1'b0, 1'b0, 3'd0, 4'd4, 4'd6, 1'b0);
    sample(8'h81, 4'd4, 3'd0, 1'b0);
    sample(8'h06, 4'd5, 3'd0, 1'b0);
    sample(8'h01, 4'd6, 3'd1, 1'b0);
    sample(8'h81, 4'd7, 3'd1, 1'b0);
    status(1'b0, 1'b1, 1'b1, 3'd1, 4'd8, 4'd7, 1'b0);

    // Abort together with start in WAIT
    cfg(8'h01, 1'b0, 16'd0, 8'h00, 1'b0, 16'd0, 3'd0, 4'd2, 4'd2);
    pulse(1'b1, 1'b0);
    sample(8'h00, 4'd0, 3'd0, 1'b0);
    sample(8'h00, 4'd1, 3'd0, 1'b0);
    sample(8'h00, 4'd2, 3'd0, 1'b0);
    status(1'b1, 1'b0, 1'b0, 3'd0, 4'd3, 4'd7, 1'b0);
    pulse(1'b1, 1'b1);
    status(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd7, 1'b0);

    // Re-arm; 20 WAIT samples wrap the address, then trigger at 6
    pulse(1'b1, 1'b0);
    sample(8'h00, 4'd0, 3'd0, 1'b0);
    sample(8'h00, 4'd1, 3'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      a = 4'((2 + i) % 16);
      sample(8'h00, a, 3'd0, 1'b0);
      if (i == 9)
        pulse(1'b1, 1'b0);                                // start while busy: ignored
    end
    sample(8'h01, 4'd6, 3'd0, 1'b0);
    sample(8'h00, 4'd7, 3'd0, 1'b1);
    status(1'b0, 1'b1, 1'b1, 3'd0, 4'd8, 4'd6, 1'b0);

`ifdef TRIG_TIMEOUT_EN
    // Forced trigger on the 5th WAIT sample
    cfg(8'h01, 1'b0, 16'd0, 8'h00, 1'b0, 16'd0, 3'd0, 4'd1, 4'd1);
    bus.timeout = 32'd5;
    pulse(1'b1, 1'b0);
    sample(8'h00, 4'd0, 3'd0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      a = 4'(i);
      sample(8'h00, a, 3'd0, 1'b0);
    end
    status(1'b0, 1'b1, 1'b1, 3'd0, 4'd6, 4'd5, 1'b1);
    pulse(1'b0, 1'b1);
    status(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd5, 1'b0);
    bus.timeout = 32'd0;
`endif

    idle(2, 1'b0);
    fin_req = 1'b1;
  end

endmodule

// File: doc/la_trigger_sequencer.md
# la_trigger_sequencer

Multi-stage trigger sequencer and capture controller for the logic analyzer. It consumes the per-channel match vector produced by the bank of basic trigger comparators and walks up to `STAGES` programmable trigger stages. It also sequences the capture window (pre-trigger fill, trigger wait, post-trigger fill) and drives the write enable and address of the sample buffer. It sits between the host register block (configuration, start/abort) and the sample memory.

## Interface
- `CH_NUM`, 8, number of comparator match lines in `trig_vec`
- `STAGES`, 4, number of trigger stages (2..8)
- `CNT_W`, 16, width of per-stage match counters
- `ADDR_W`, 12, sample buffer address width; buffer depth is 2^ADDR_W
- `clk`  in  1  analyzer sample-domain clock
- `rstn`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle pulse; arms a capture from IDLE or DONE
- `abort`  in  1  level/pulse; returns to IDLE from any state
- `sample_en`  in  1  sample strobe; all evaluation and counting occurs only when high
- `trig_vec`  in  CH_NUM  per-channel comparator match results
- `stage_mask`  in  STAGES*CH_NUM  channels participating in each stage (stage k at `[k*CH_NUM +: CH_NUM]`)
- `stage_or`  in  STAGES  per stage: 0 = AND of masked channels, 1 = OR
- `stage_cnt`  in  STAGES*CNT_W  required matches minus one per stage
- `stage_last`  in  3  index of final active stage (clamped to STAGES-1)
- `pre_depth`  in  ADDR_W  pre-trigger samples to collect before evaluation starts
- `post_depth`  in  ADDR_W  samples to collect after trigger, trigger sample included
- `busy`  out  1  high in PRE, WAIT, POST
- `triggered`  out  1  set on final-stage hit, held until next start/abort
- `done`  out  1  high in DONE
- `cur_stage`  out  3  stage currently being evaluated
- `buf_we`  out  1  sample buffer write enable
- `buf_addr`  out  ADDR_W  sample buffer write address
- `trig_addr`  out  ADDR_W  buffer address of the trigger sample

## Operation
- States: IDLE, PRE, WAIT, POST, DONE. Encoded in a registered state machine.
- IDLE/DONE + `start` → PRE. Clears `buf_addr`, `cur_stage`, the stage match counter, `triggered` and the post counter.
- PRE: each `sample_en` writes one sample and increments the pre counter. After `pre_depth` samples → WAIT. `pre_depth`=0 goes straight to WAIT on the next cycle.
- WAIT: writes continue; `buf_addr` wraps modulo 2^ADDR_W (circular pre-trigger history). Each sample evaluates stage `cur_stage`:
  - AND: `&(trig_vec | ~mask)`.
  - OR: `|(trig_vec & mask)`.
  - An all-zero mask matches unconditionally in both modes.
- Stage hit: the match counter increments (matches need not be consecutive). When the count reaches `stage_cnt`+1, the counter clears and the stage advances.
- Advancing past `stage_last` is the trigger event:
  - `triggered` sets.
  - `trig_addr` latches the current `buf_addr`.
  - State → POST.
- POST: the trigger sample counts as the first post sample. After `post_depth` total samples (0 treated as 1) → DONE. `buf_we` stops.
- `abort` has priority over every transition: state → IDLE, outputs cleared except `trig_addr`.
- `start` while busy is ignored.
- Configuration inputs are sampled live; the host must hold them stable while busy.

## Timing
- Reset values: state IDLE; `busy`, `triggered`, `done` = 0; `cur_stage`, `buf_addr`, `trig_addr` = 0; counters 0.
- `buf_we = sample_en & busy-state`. It is combinational from the state register so the write aligns with the current sample. `buf_addr` increments at the edge following each write.
- A matching sample at edge N updates the counter, stage or state at edge N+1. `trig_addr` equals the address written at edge N.
- `start` and `abort` in the same cycle: abort wins.
- `sample_en` low freezes all counters and state except `start`/`abort` handling.
- Reset mid-capture returns to IDLE immediately (asynchronous).

## Configuration
- `TRIG_TIMEOUT_EN`: when defined, adds input `timeout` [31:0] and output `timed_out`.
  - In WAIT, a sample counter is compared against `timeout`. On reaching `timeout` (nonzero), a forced trigger occurs identical to a normal trigger, and `timed_out` sets. `timed_out` clears on start/abort.
  - `timeout`=0 disables the forced trigger.
- Without the macro, WAIT persists until the stages complete or `abort`; no timeout logic or ports exist.

## Test plan
- pre_depth=4, one stage, AND mask=0x01, cnt=0; channel 0 asserted on the 7th sample → `trig_addr`=6, `triggered`=1, POST with post_depth=3 writes addresses 6..8, `done` one cycle after the 3rd post write.
- Two stages, stage0 OR mask=0x06 cnt=2, stage1 AND mask=0x81; three non-consecutive stage0 hits, then a trig_vec=0x81 sample → `cur_stage` 0→1→trigger.
- ADDR_W=4, pre_depth=2, trigger after 20 WAIT samples → `buf_addr` wraps 15→0, `trig_addr`=(2+20)%16=6.
- `abort` asserted in WAIT with `start` in the same cycle → IDLE, `busy`=0, `triggered`=0; a later `start` re-arms normally.
- `sample_en` held low for 10 cycles mid-WAIT with matching trig_vec → no counter or stage change.
- With `TRIG_TIMEOUT_EN`, timeout=5, no matches → forced trigger on the 5th WAIT sample, `timed_out`=1, `triggered`=1.
